puf_soc_counter: RTL and testbench

PUF_SOC_COUNTER -- requirements
Module: puf_soc_counter

---
 rtl/puf_soc_counter_if.sv | 22 ++
 rtl/puf_soc_counter.sv | 76 +++++++
 tb/tb_puf_soc_counter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/puf_soc_counter_if.sv
// Bus bundle for puf_soc_counter: control inputs (i_*) and registered status/count (o_*).
// The master modport drives the controls; the counter attaches through the slave modport.
interface puf_soc_counter_if #(
  parameter int CNT_BIT_SIZE = 32
);
  logic                    i_cnt_en;
  logic [CNT_BIT_SIZE-1:0] i_cnt_max;
  logic                    i_op_mode;
  logic                    o_valid;
  logic [CNT_BIT_SIZE-1:0] o_cnt;
  logic                    o_cnt_full;

  modport master (
    output i_cnt_en, i_cnt_max, i_op_mode,
    input  o_valid, o_cnt, o_cnt_full
  );

  modport slave (
    input  i_cnt_en, i_cnt_max, i_op_mode,
    output o_valid, o_cnt, o_cnt_full
  );
endinterface

// File: rtl/puf_soc_counter.sv
// Saturating up-counter with IDLE/COUNT/HOLD/FULL control and a registered valid flag.
// Optional build macro PUF_CNT_AUTO_RESTART_EN makes FULL a one-cycle state that restarts counting from 0.
module puf_soc_counter #(
  parameter int CNT_BIT_SIZE = 32
) (
  input logic               clk,
  input logic               rst,
  puf_soc_counter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, COUNT, HOLD, FULL} state_t;

  state_t                  state_q, state_d;
  logic [CNT_BIT_SIZE-1:0] cnt_q, cnt_d;
  logic [CNT_BIT_SIZE-1:0] cnt_inc;
  logic                    valid_q, valid_d;

  // Only evaluated when cnt_q < i_cnt_max, so this never wraps.
  assign cnt_inc = cnt_q + CNT_BIT_SIZE'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.i_op_mode)     state_d = HOLD;
        else if (bus.i_cnt_en) state_d = COUNT;
      end
      COUNT: begin
        if (bus.i_op_mode) begin
          state_d = HOLD;
        end else if (bus.i_cnt_en) begin
          // A lowered terminal value ends counting without touching the count.
          if (cnt_q >= bus.i_cnt_max) begin
            state_d = FULL;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc >= bus.i_cnt_max) state_d = FULL;
          end
        end
      end
      HOLD: begin
        if (!bus.i_op_mode) state_d = COUNT;
      end
      FULL: begin
`ifdef PUF_CNT_AUTO_RESTART_EN
        cnt_d   = '0;
        state_d = COUNT;
`else
        state_d = FULL;
`endif
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    valid_d = (state_d == HOLD) || (state_d == FULL);
  end

  assign bus.o_cnt      = cnt_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_cnt_full = (state_q == FULL);
endmodule

// File: tb/tb_puf_soc_counter.sv
// Directed bench for puf_soc_counter: each step queues the expected outputs, clocks once,
// then pops and checks them; asynchronous reset is checked between clock edges.
module tb_puf_soc_counter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    logic [W-1:0] cnt;
    logic         valid;
    logic         full;
    string        tag;
  } exp_t;

  exp_t exp_q[$];

  puf_soc_counter_if #(.CNT_BIT_SIZE(W)) bus ();

  puf_soc_counter #(.CNT_BIT_SIZE(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input logic [W-1:0] c, input logic v, input logic f, input string tag);
    exp_t e;
    e.cnt = c; e.valid = v; e.full = f; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty got=0 entries exp=1");
      return;
    end
    e = exp_q.pop_front();
    $display("t=%0t %s cnt=%0d valid=%0b full=%0b", $time, e.tag, bus.o_cnt, bus.o_valid, bus.o_cnt_full);
    assert (bus.o_cnt === e.cnt) else begin
      bad++;
      $error("FAIL %s cnt got=%0d exp=%0d", e.tag, bus.o_cnt, e.cnt);
    end
    total++;
    assert (bus.o_valid === e.valid) else begin
      bad++;
      $error("FAIL %s valid got=%0b exp=%0b", e.tag, bus.o_valid, e.valid);
    end
    total++;
    assert (bus.o_cnt_full === e.full) else begin
      bad++;
      $error("FAIL %s full got=%0b exp=%0b", e.tag, bus.o_cnt_full, e.full);
    end
  endtask

  // Drive inputs, queue expectation, take one edge, then compare just after it.
  task automatic step(input logic en, input logic mode, input logic [W-1:0] max,
                      input logic [W-1:0] c, input logic v, input logic f, input string tag);
    bus.i_cnt_en  = en;
    bus.i_op_mode = mode;
    bus.i_cnt_max = max;
    push_exp(c, v, f, tag);
    @(posedge clk);
    #1;
    check_out();
  endtask

  // Pulse reset between edges and check outputs clear without a clock.
  task automatic async_rst_pulse(input string tag);
    #2;
    rst = 1'b1;
    #1;
    push_exp('0, 1'b0, 1'b0, tag);
    check_out();
    rst = 1'b0;
  endtask

  initial begin
    bus.i_cnt_en  = 1'b0;
    bus.i_op_mode = 1'b0;
    bus.i_cnt_max = W'(1024);

    repeat (5) begin
      @(posedge clk);
      #1;
      push_exp('0, 1'b0, 1'b0, "reset_hold");
      check_out();
    end
    rst = 1'b0;

    step(1, 0, 1024, 0, 0, 0, "idle_to_count");
    for (int i = 1; i <= 50; i++) step(1, 0, 1024, W'(i), 0, 0, "count");
    repeat (7) step(0, 0, 1024, 50, 0, 0, "enable_low");
    for (int i = 51; i <= 499; i++) step(1, 0, 1024, W'(i), 0, 0, "count");

    step(0, 1, 1024, 499, 1, 0, "hold_enter");
    step(0, 1, 1024, 499, 1, 0, "hold_stay");
    step(1, 0, 1024, 499, 0, 0, "hold_exit");
    for (int i = 500; i <= 1023; i++) step(1, 0, 1024, W'(i), 0, 0, "count");
    step(1, 0, 1024, 1024, 1, 1, "terminal");
`ifdef PUF_CNT_AUTO_RESTART_EN
    step(1, 0, 1024, 0, 0, 0, "auto_restart");
    step(1, 0, 1024, 1, 0, 0, "restart_count");
`else
    repeat (10) step(1, 0, 1024, 1024, 1, 1, "full_persist");
    step(0, 1, 1024, 1024, 1, 1, "full_ignore_mode");
`endif
    async_rst_pulse("async_rst_full");

    step(1, 0, 1024, 0, 0, 0, "idle_to_count");
    for (int i = 1; i <= 20; i++) step(1, 0, 1024, W'(i), 0, 0, "count");
    step(1, 1, 1024, 20, 1, 0, "mode_priority");
    step(0, 0, 1024, 20, 0, 0, "hold_exit");
    step(1, 0, 10, 20, 1, 1, "max_lowered");
`ifdef PUF_CNT_AUTO_RESTART_EN
    step(0, 0, 10, 0, 0, 0, "auto_restart");
`else
    step(1, 0, 10, 20, 1, 1, "full_persist");
`endif
    async_rst_pulse("async_rst_after_lower");

    step(1, 0, 0, 0, 0, 0, "max0_idle_to_count");
    step(1, 0, 0, 0, 1, 1, "max0_full");
    async_rst_pulse("async_rst_max0");

    step(1, 0, 1024, 0, 0, 0, "idle_to_count");
    for (int i = 1; i <= 300; i++) step(1, 0, 1024, W'(i), 0, 0, "count");
    async_rst_pulse("async_rst_at_300");

    step(0, 1, 1024, 0, 1, 0, "idle_to_hold");
    step(1, 0, 1024, 0, 0, 0, "hold_to_count");
    step(1, 0, 1024, 1, 0, 0, "count_after_hold");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
